// File: rtl/nco_tone_detector.sv
// Tone detector for a sampled NCO/LUT stream: measures the period between rising
// zero crossings (with hysteresis), declares lock after LOCK_N matching periods.
module nco_tone_detector #(
   parameter int SAMPLE_W = 32,
   parameter int CNT_W    = 16,
   parameter int HYST     = 0,
   parameter int TOL      = 1,
   parameter int LOCK_N   = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                EN,
   input  logic [SAMPLE_W-1:0] d,
   output logic [CNT_W-1:0]    period,
   output logic                period_valid,
   output logic                locked,
   output logic                tone_lost,
   output logic [1:0]          fsm_state
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   localparam logic signed [SAMPLE_W-1:0] HYST_P = SAMPLE_W'(HYST);
   localparam logic signed [SAMPLE_W-1:0] HYST_N = -HYST_P;

   logic [1:0]                 state;
   logic                       armed;
   logic                       have_prev;
   logic [CNT_W-1:0]           cnt;
   logic [3:0]                 mcnt;
   logic [3:0]                 mcnt_next;
   logic [CNT_W-1:0]           diff;
   logic signed [SAMPLE_W-1:0] d_s;
   logic                       arm_set;
   logic                       crossing;
   logic                       saturate;
   logic                       match;

   assign d_s       = d;
   assign arm_set   = d_s < HYST_N;
   assign crossing  = armed && (d_s >= HYST_P);
   assign saturate  = (&cnt) && !crossing;
   assign fsm_state = state;

   // The period register doubles as the previous period; have_prev gates the
   // comparison so the first period after IDLE never matches.
   always_comb begin
      diff = (cnt >= period) ? (cnt - period) : (period - cnt);
      match = have_prev && (diff <= CNT_W'(TOL));
      if (!match) mcnt_next = 4'd0;
      else if (mcnt >= 4'(LOCK_N)) mcnt_next = mcnt;
      else mcnt_next = mcnt + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         armed        <= 1'b0;
         have_prev    <= 1'b0;
         cnt          <= '0;
         mcnt         <= 4'd0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         tone_lost    <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         tone_lost    <= 1'b0;
         if (EN) begin
            if (crossing) armed <= 1'b0;
            else if (arm_set) armed <= 1'b1;

            if (crossing) cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (saturate) cnt <= '0;
            else cnt <= cnt + 1'b1;

            if (crossing) begin
               if (state == ST_IDLE) begin
                  state     <= ST_MEASURE;
                  have_prev <= 1'b0;
                  mcnt      <= 4'd0;
               end else begin
                  period       <= cnt;
                  period_valid <= 1'b1;
                  have_prev    <= 1'b1;
                  mcnt         <= mcnt_next;
                  if (mcnt_next == 4'(LOCK_N)) begin
                     state  <= ST_LOCKED;
                     locked <= 1'b1;
                  end else begin
                     state  <= ST_MEASURE;
                     locked <= 1'b0;
                  end
               end
            end

            // Counter overflow without a crossing means the tone is gone.
            if (saturate) begin
               state     <= ST_IDLE;
               locked    <= 1'b0;
               mcnt      <= 4'd0;
               armed     <= 1'b0;
               have_prev <= 1'b0;
               tone_lost <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_nco_tone_detector.sv
// Directed bench for nco_tone_detector: lock, EN gaps, reset, period change,
// counter saturation and hysteresis on three differently parameterised instances.
module tb_nco_tone_detector;

   logic        clk;
   logic        rst_n;
   logic        en, en_s, en_h;
   logic [31:0] d, d_s, d_h;
   logic [15:0] period;
   logic [5:0]  period_s, period_h;
   logic        pv, pv_s, pv_h;
   logic        lk, lk_s, lk_h;
   logic        tl, tl_s, tl_h;
   logic [1:0]  st, st_s, st_h;

   int checks = 0;
   int errors = 0;

   nco_tone_detector dut (
      .clk(clk), .rst_n(rst_n), .EN(en), .d(d), .period(period),
      .period_valid(pv), .locked(lk), .tone_lost(tl), .fsm_state(st)
   );

   nco_tone_detector #(.CNT_W(6)) dut_s (
      .clk(clk), .rst_n(rst_n), .EN(en_s), .d(d_s), .period(period_s),
      .period_valid(pv_s), .locked(lk_s), .tone_lost(tl_s), .fsm_state(st_s)
   );

   nco_tone_detector #(.CNT_W(6), .HYST(50)) dut_h (
      .clk(clk), .rst_n(rst_n), .EN(en_h), .d(d_h), .period(period_h),
      .period_valid(pv_h), .locked(lk_h), .tone_lost(tl_h), .fsm_state(st_h)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input int v);
      en = 1'b1; d = v;
      @(posedge clk); #1;
   endtask

   task automatic push_s(input int v);
      en_s = 1'b1; d_s = v;
      @(posedge clk); #1;
   endtask

   task automatic push_h(input int v);
      en_h = 1'b1; d_h = v;
      @(posedge clk); #1;
   endtask

   // One tone cycle of half samples at +100 then half at -100; the crossing
   // sample is the first one, so its outputs are captured after that push.
   task automatic run_cycle(input int half, output logic pv0, output logic [15:0] per0,
                            output logic lk0, output int extra);
      extra = 0;
      pv0 = 1'b0; per0 = '0; lk0 = 1'b0;
      for (int i = 0; i < 2 * half; i++) begin
         push((i < half) ? 100 : -100);
         if (i == 0) begin
            pv0 = pv; per0 = period; lk0 = lk;
         end else if (pv || tl) begin
            extra++;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; en = 1'b0; en_s = 1'b0; en_h = 1'b0;
      d = '0; d_s = '0; d_h = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (period !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period); end
      checks++; if (pv !== 1'b0) begin errors++; $display("FAIL reset_pv: got %0b expected 0", pv); end
      checks++; if (lk !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", lk); end
      checks++; if (tl !== 1'b0) begin errors++; $display("FAIL reset_tone_lost: got %0b expected 0", tl); end
      checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic lock_sequence(input string tag);
      logic pv0, lk0;
      logic [15:0] per0;
      int extra;
      for (int c = 1; c <= 6; c++) begin
         run_cycle(4, pv0, per0, lk0, extra);
         checks++; if (pv0 !== (c >= 3)) begin errors++; $display("FAIL %s_pv c%0d: got %0b expected %0b", tag, c, pv0, (c >= 3)); end
         if (c >= 3) begin
            checks++; if (per0 !== 16'd8) begin errors++; $display("FAIL %s_period c%0d: got %0d expected 8", tag, c, per0); end
         end
         checks++; if (lk0 !== (c == 6)) begin errors++; $display("FAIL %s_locked c%0d: got %0b expected %0b", tag, c, lk0, (c == 6)); end
         checks++; if (extra !== 0) begin errors++; $display("FAIL %s_extra_pulse c%0d: got %0d expected 0", tag, c, extra); end
      end
   endtask

   task automatic test_lock;
      lock_sequence("lock");
   endtask

   task automatic test_en_gap;
      logic pv0, lk0;
      logic [15:0] per0;
      int extra;
      int bad;
      push(100);
      checks++; if (pv !== 1'b1 || period !== 16'd8 || lk !== 1'b1) begin errors++; $display("FAIL gap_entry: got pv=%0b per=%0d lk=%0b expected 1 8 1", pv, period, lk); end
      push(100);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         en = 1'b0; d = (i % 2) ? 32'd500 : -32'sd500;
         @(posedge clk); #1;
         if (pv !== 1'b0 || tl !== 1'b0 || lk !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL gap_idle_pulses: got %0d bad cycles expected 0", bad); end
      push(100); push(100);
      for (int i = 0; i < 4; i++) push(-100);
      run_cycle(4, pv0, per0, lk0, extra);
      checks++; if (pv0 !== 1'b1 || per0 !== 16'd8) begin errors++; $display("FAIL gap_period: got pv=%0b per=%0d expected 1 8", pv0, per0); end
      checks++; if (lk0 !== 1'b1) begin errors++; $display("FAIL gap_locked: got %0b expected 1", lk0); end
   endtask

   task automatic test_reset_mid;
      push(100);
      push(100);
      rst_n = 1'b0; en = 1'b0;
      #1;
      checks++; if (period !== 16'd0 || pv !== 1'b0 || lk !== 1'b0 || tl !== 1'b0 || st !== 2'd0) begin
         errors++; $display("FAIL rstmid_async: got per=%0d pv=%0b lk=%0b tl=%0b st=%0d expected all 0", period, pv, lk, tl, st);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      lock_sequence("rstmid");
   endtask

   task automatic test_period_change;
      logic pv0, lk0;
      logic [15:0] per0;
      int extra;
      run_cycle(6, pv0, per0, lk0, extra);
      checks++; if (pv0 !== 1'b1 || per0 !== 16'd8 || lk0 !== 1'b1) begin errors++; $display("FAIL chg_last8: got pv=%0b per=%0d lk=%0b expected 1 8 1", pv0, per0, lk0); end
      for (int c = 1; c <= 4; c++) begin
         run_cycle(6, pv0, per0, lk0, extra);
         checks++; if (pv0 !== 1'b1 || per0 !== 16'd12) begin errors++; $display("FAIL chg_period c%0d: got pv=%0b per=%0d expected 1 12", c, pv0, per0); end
         checks++; if (lk0 !== (c == 4)) begin errors++; $display("FAIL chg_locked c%0d: got %0b expected %0b", c, lk0, (c == 4)); end
         checks++; if (extra !== 0) begin errors++; $display("FAIL chg_extra c%0d: got %0d expected 0", c, extra); end
      end
   endtask

   task automatic test_saturation;
      int bad;
      push_s(-10); push_s(10);
      checks++; if (st_s !== 2'd1 || pv_s !== 1'b0) begin errors++; $display("FAIL sat_first_cross: got st=%0d pv=%0b expected 1 0", st_s, pv_s); end
      push_s(-10); push_s(-10); push_s(-10); push_s(10);
      checks++; if (pv_s !== 1'b1 || period_s !== 6'd4) begin errors++; $display("FAIL sat_period4: got pv=%0b per=%0d expected 1 4", pv_s, period_s); end
      bad = 0;
      for (int i = 0; i < 62; i++) begin
         push_s(0);
         if (tl_s !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL sat_early_lost: got %0d pulses expected 0", bad); end
      push_s(0);
      checks++; if (tl_s !== 1'b1) begin errors++; $display("FAIL sat_lost: got %0b expected 1", tl_s); end
      checks++; if (st_s !== 2'd0 || period_s !== 6'd4 || lk_s !== 1'b0) begin errors++; $display("FAIL sat_after: got st=%0d per=%0d lk=%0b expected 0 4 0", st_s, period_s, lk_s); end
      push_s(0);
      checks++; if (tl_s !== 1'b0) begin errors++; $display("FAIL sat_lost_width: got %0b expected 0", tl_s); end
      push_s(-10); push_s(10);
      for (int i = 0; i < 61; i++) push_s(0);
      push_s(-10);
      push_s(10);
      checks++; if (pv_s !== 1'b1 || period_s !== 6'd63 || tl_s !== 1'b0) begin errors++; $display("FAIL sat_cross_prio: got pv=%0b per=%0d tl=%0b expected 1 63 0", pv_s, period_s, tl_s); end
   endtask

   task automatic test_hysteresis;
      int bad;
      bad = 0;
      for (int i = 0; i < 63; i++) begin
         push_h((i % 2) ? -30 : 30);
         if (tl_h !== 1'b0 || pv_h !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL hyst_no_events: got %0d bad samples expected 0", bad); end
      push_h(-30);
      checks++; if (tl_h !== 1'b1 || st_h !== 2'd0) begin errors++; $display("FAIL hyst_lost: got tl=%0b st=%0d expected 1 0", tl_h, st_h); end
      push_h(-50); push_h(50);
      checks++; if (st_h !== 2'd0) begin errors++; $display("FAIL hyst_edge_arm: got st=%0d expected 0", st_h); end
      push_h(-51); push_h(49);
      checks++; if (st_h !== 2'd0) begin errors++; $display("FAIL hyst_edge_cross: got st=%0d expected 0", st_h); end
      push_h(50);
      checks++; if (st_h !== 2'd1 || pv_h !== 1'b0) begin errors++; $display("FAIL hyst_cross: got st=%0d pv=%0b expected 1 0", st_h, pv_h); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_en_gap();
      test_reset_mid();
      test_period_change();
      en = 1'b0;
      test_saturation();
      en_s = 1'b0;
      test_hysteresis();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nco_tone_detector.md
NCO_TONE_DETECTOR -- requirements
Module: nco_tone_detector

Interface
REQ-001 Parameter SAMPLE_W, default 32, meaning: input sample width, signed two's complement.
REQ-002 Parameter CNT_W, default 16, meaning: period counter and period output width.
REQ-003 Parameter HYST, default 0, meaning: non-negative crossing hysteresis threshold, in LSBs.
REQ-004 Parameter TOL, default 1, meaning: maximum allowed difference between consecutive periods for a match, in samples.
REQ-005 Parameter LOCK_N, default 3, meaning: consecutive matching periods required for lock (1..15).
REQ-006 The module SHALL provide `clk`, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL provide `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL provide `EN`, input, 1 bit: sample-valid qualifier; the sample on `d` is consumed only in cycles where EN=1.
REQ-009 The module SHALL provide `d`, input, SAMPLE_W bits: signed sample stream, i.e. the registered NCO/LUT output.
REQ-010 The module SHALL provide `period`, output, CNT_W bits: last measured period, in samples.
REQ-011 The module SHALL provide `period_valid`, output, 1 bit: one-cycle pulse when `period` updates.
REQ-012 The module SHALL provide `locked`, output, 1 bit: stable tone detected.
REQ-013 The module SHALL provide `tone_lost`, output, 1 bit: one-cycle pulse on counter saturation.

Function
REQ-014 All state SHALL advance only in cycles with EN=1; with EN=0 every register SHALL hold, and pulses SHALL be 0.
REQ-015 Crossing detector: an arm flag SHALL set on a sample < -HYST; a crossing SHALL fire on a sample >= HYST while armed, and SHALL clear the arm flag in that same cycle.
REQ-016 Sample counter: it SHALL increment by 1 per consumed sample; on a crossing it SHALL load 1 (the crossing sample counts as the first sample of the new period).
REQ-017 FSM states: IDLE, MEASURE, LOCKED.
REQ-018 IDLE: on a crossing, go to MEASURE and load the counter to 1; no period_valid.
REQ-019 MEASURE/LOCKED: on a crossing, period <= counter value before the reload, and period_valid=1 in the next cycle, registered.
REQ-020 Match rule: |new period - previous period| <= TOL, computed unsigned without wrap; the first period after IDLE SHALL never match.
REQ-021 Match counter: +1 on match, saturating at LOCK_N; reset to 0 on mismatch.
REQ-022 MEASURE -> LOCKED when the match counter reaches LOCK_N; locked=1 from the same cycle period_valid asserts.
REQ-023 LOCKED -> MEASURE on a mismatched period; locked drops with that period_valid; the match counter becomes 0.
REQ-024 Saturation: counter at 2^CNT_W-1 with a consumed sample and no crossing -> tone_lost pulse, state IDLE, locked=0, match counter 0, arm flag cleared; period holds its old value.
REQ-025 A crossing coinciding with saturation SHALL take priority: measure period = 2^CNT_W-1, with no tone_lost.
REQ-026 Outputs SHALL be registered; no combinational path from d or EN to any output.

Reset
REQ-027 While rst_n=0: state IDLE, period=0, period_valid=0, locked=0, tone_lost=0, counters 0, arm flag 0, asynchronously.
REQ-028 Reset asserted mid-measurement SHALL discard the partial count; after release, the first crossing only re-arms timing (IDLE rule).
REQ-029 Reset deassertion SHALL take effect on the next clk edge; no sample is consumed in the release cycle's edge.

Verification
REQ-030 EN=1, d repeating +100 x4, -100 x4 -> first period_valid with period=8 on the second crossing; locked=1 on the 4th period_valid (LOCK_N=3).
REQ-031 Locked at period 8, then switch to period 12 -> period_valid with period=12 and locked=0; relock after 3 further periods of 12.
REQ-032 Period-8 stream with EN=0 for 5 cycles inside a period -> period still 8, no spurious pulses while EN=0.
REQ-033 CNT_W=6, constant d=0 after one crossing -> tone_lost on the 63rd consumed sample after the crossing, state IDLE, period unchanged.
REQ-034 HYST=50, d alternating +30/-30 -> no crossing, no period_valid; counter saturates -> tone_lost.
REQ-035 Locked at period 8, then rst_n=0 for 2 cycles -> all outputs 0 immediately; after release, first period_valid occurs only after two crossings.
